mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store initiator for the 64-bit byte-banked data memory (Memoria64): the master end of its raddress/waddress/Datain/Dataout/Wr port.
//  Accepts one CPU request at a time and returns a single-cycle response.
//  Loads: B/H/W/D with sign or zero extension.
//  Stores: D writes directly; B/H/W use read-modify-write, because the memory always writes 8 bytes.
// PARAMETERS
//  MEM_RD_LAT  1  cycles from mem_raddress stable to valid mem_dataout (legal 1..3)
// PORTS
//  Clk            in   1   clock, rising edge
//  Reset_n        in   1   asynchronous, active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   unit idle, can accept; accept = req_valid & req_ready
//  req_write      in   1   1=store, 0=load
//  req_size       in   2   00=byte 01=half 10=word 11=dword
//  req_unsigned   in   1   load: 1=zero-extend, 0=sign-extend; ignored for stores
//  req_addr       in   64  byte address (passed unmodified to memory)
//  req_wdata      in   64  store data, low-order bytes used per req_size
//  rsp_valid      out  1   one-cycle response pulse (no backpressure)
//  rsp_rdata      out  64  extended load data; 0 for stores
//  rsp_err        out  1   misaligned request (see CONFIGURATION)
//  mem_raddress   out  64  to memory raddress
//  mem_waddress   out  64  to memory waddress
//  mem_datain     out  64  to memory Datain
//  mem_dataout    in   64  from memory Dataout; byte i = mem[addr+i]
//  mem_wr         out  1   to memory Wr
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; rsp_valid/rsp_err/mem_wr=0; rsp_rdata, mem_raddress, mem_waddress, mem_datain=0.
//  - FSM states: IDLE, RD_WAIT, WRITE, RESP.
//  - IDLE: req_ready=1. On accept, latch addr/size/unsigned/write/wdata into addr_q etc.
//    - load or sub-word store -> RD_WAIT
//    - dword store -> WRITE
//  - mem_raddress = mem_waddress = addr_q from the cycle after accept; held until the next accept.
//  - RD_WAIT: counter runs MEM_RD_LAT cycles. On the last cycle, mem_dataout is sampled.
//    - load -> RESP
//    - store -> WRITE, with merged data loaded into mem_datain
//  - Merge (store): low bytes come from wdata_q, the rest from the read data.
//    - B = {rd[63:8], wd[7:0]}
//    - H = {rd[63:16], wd[15:0]}
//    - W = {rd[63:32], wd[31:0]}
//    - D = wd
//  - WRITE: mem_wr=1 for exactly one cycle; rsp_valid=1 in the same cycle, rsp_rdata=0 -> IDLE.
//  - RESP: rsp_valid=1 for one cycle with extended data -> IDLE.
//    - B extends bit 7; H bit 15; W bit 31; D raw.
//  - Latency (accept at edge T; counts are in cycles after T):
//    - load: rsp_valid at T+1+MEM_RD_LAT
//    - dword store: mem_wr/rsp_valid at T+1
//    - sub-word store: mem_wr/rsp_valid at T+1+MEM_RD_LAT
//    - next accept possible one cycle after rsp_valid
//  - req_ready=0 in all states except IDLE; req_valid while busy is ignored (single outstanding request).
//  - Back-to-back store then load to the same address returns the new data: the write commits at the WRITE edge, before the load's read.
//  - Address wrap: the unit never modifies addresses. The memory uses addr[15:0] and its byte lanes wrap modulo 2^16; the unit adds no checks.
//  - Reset asserted mid-operation: immediate return to IDLE; a pending mem_wr and rsp_valid are never issued.
//  - rsp_rdata holds its value until the next response; rsp_err is valid only with rsp_valid.
// CONFIGURATION
//  ALIGN_CHECK_EN defined:
//    - An access is misaligned when addr[2:0] is not a multiple of the size (H: addr[0]!=0; W: addr[1:0]!=0; D: addr[2:0]!=0).
//    - Misaligned access: IDLE -> RESP; rsp_valid=1 and rsp_err=1 at T+1, rsp_rdata=0.
//    - No mem_wr is issued and memory is not accessed.
//  ALIGN_CHECK_EN undefined:
//    - Unaligned accesses are performed normally; the memory banks handle any byte address.
//    - rsp_err is tied 0.
// TESTING
//  1 Reset: Reset_n=0 -> req_ready=1, mem_wr=0, rsp_valid=0, all buses 0; release -> still IDLE.
//  2 D store 0x0123456789ABCDEF @0x10 -> mem_wr=1 at T+1, waddr=0x10, datain same.
//    D load @0x10 -> rsp_rdata=0x0123456789ABCDEF at T+1+MEM_RD_LAT.
//  3 Memory 0x18..0x1F preloaded 0. B store 0xAA @0x12 -> mem_wr at T+1+LAT, waddr 0x12, datain=0x000001234567_89AA.
//    D load @0x10 -> 0x0123456789AACDEF.
//  4 Loads on memory from 2:
//    - signed B @0x11 -> 0xFFFFFFFFFFFFFFCD
//    - unsigned B @0x11 -> 0x00000000000000CD
//    - signed H @0x10 -> 0xFFFFFFFFFFFFCDEF
//    - unsigned W @0x10 -> 0x0000000089ABCDEF
//  5 Reset_n pulsed low during RD_WAIT of an H store -> no mem_wr, no rsp_valid, req_ready=1 after release; memory unchanged.
//  6 W load @0x13:
//    - with ALIGN_CHECK_EN: rsp_valid=1, rsp_err=1 at T+1, no memory access.
//    - without: rsp_rdata = bytes 0x13..0x16 zero/sign-extended, rsp_err=0.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// ---------------------------------------------------------------------------
// mem_access_unit_if
//   Bundles the CPU request/response handshake and the Memoria64 port of the
//   load/store unit.
//   slave  : view of the unit (takes requests, drives the memory port)
//   master : view of the environment (issues requests, returns Dataout)
//   Request : req_valid, req_ready, req_write, req_size, req_unsigned,
//             req_addr, req_wdata
//   Response: rsp_valid, rsp_rdata, rsp_err
//   Memory  : mem_raddress, mem_waddress, mem_datain, mem_dataout, mem_wr
// ---------------------------------------------------------------------------
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] mem_raddress;
    logic [63:0] mem_waddress;
    logic [63:0] mem_datain;
    logic [63:0] mem_dataout;
    logic        mem_wr;

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_dataout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_raddress, mem_waddress, mem_datain, mem_wr
    );

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output mem_dataout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_raddress, mem_waddress, mem_datain, mem_wr
    );
endinterface

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   Load/store initiator for the 64-bit byte-banked data memory. One request
//   in flight; single-cycle response pulse.
//   Loads : B/H/W/D with sign or zero extension.
//   Stores: D written directly; B/H/W read-modify-write since the memory
//           always writes all 8 bytes.
// Ports
//   Clk      : clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   bus      : mem_access_unit_if.slave (request, response, memory port)
// Parameters
//   MEM_RD_LAT : cycles from mem_raddress stable to valid mem_dataout (1..3)
// Optional feature
//   ALIGN_CHECK_EN : when defined, misaligned H/W/D accesses are rejected
//                    with rsp_err=1 and no memory access; otherwise rsp_err
//                    is tied 0 and unaligned accesses proceed normally.
// ---------------------------------------------------------------------------
module mem_access_unit #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    mem_access_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, WRITE, RESP} state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q,  addr_d;
    logic [1:0]  size_q,  size_d;
    logic        uns_q,   uns_d;
    logic        wr_q,    wr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [1:0]  cnt_q,   cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic [63:0] din_q,   din_d;
    logic        mis;

    // Narrow loaded data to the access size and extend from its top bit.
    function automatic logic [63:0] extend(input logic [63:0] d,
                                           input logic [1:0]  sz,
                                           input logic        u);
        case (sz)
            2'd0:    extend = {{56{~u & d[7]}},  d[7:0]};
            2'd1:    extend = {{48{~u & d[15]}}, d[15:0]};
            2'd2:    extend = {{32{~u & d[31]}}, d[31:0]};
            default: extend = d;
        endcase
    endfunction

    // Sub-word store: new low bytes over the rest of the 8-byte read.
    function automatic logic [63:0] merge(input logic [63:0] rd,
                                          input logic [63:0] wd,
                                          input logic [1:0]  sz);
        case (sz)
            2'd0:    merge = {rd[63:8],  wd[7:0]};
            2'd1:    merge = {rd[63:16], wd[15:0]};
            2'd2:    merge = {rd[63:32], wd[31:0]};
            default: merge = wd;
        endcase
    endfunction

`ifdef ALIGN_CHECK_EN
    logic mis_q, mis_d;

    always_comb begin
        case (bus.req_size)
            2'd1:    mis = bus.req_addr[0];
            2'd2:    mis = |bus.req_addr[1:0];
            2'd3:    mis = |bus.req_addr[2:0];
            default: mis = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) mis_q <= 1'b0;
        else          mis_q <= mis_d;
    end

    // Only a rejected request reaches RESP with mis_q set.
    assign mis_d       = (state_q == IDLE && bus.req_valid) ? mis : mis_q;
    assign bus.rsp_err = (state_q == RESP) & mis_q;
`else
    assign mis         = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            din_q   <= din_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        din_d   = din_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    wr_d    = bus.req_write;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 2'(MEM_RD_LAT - 1);
                    if (mis) begin
                        state_d = RESP;
                        rdata_d = '0;
                    end else if (bus.req_write && bus.req_size == 2'd3) begin
                        state_d = WRITE;
                        din_d   = bus.req_wdata;
                        rdata_d = '0;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 2'd0) begin
                    if (wr_q) begin
                        state_d = WRITE;
                        din_d   = merge(bus.mem_dataout, wdata_q, size_q);
                        rdata_d = '0;
                    end else begin
                        state_d = RESP;
                        rdata_d = extend(bus.mem_dataout, size_q, uns_q);
                    end
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read and write addresses are the same latched request address.
    assign bus.req_ready    = (state_q == IDLE);
    assign bus.rsp_valid    = (state_q == RESP) || (state_q == WRITE);
    assign bus.rsp_rdata    = rdata_q;
    assign bus.mem_raddress = addr_q;
    assign bus.mem_waddress = addr_q;
    assign bus.mem_datain   = din_q;
    assign bus.mem_wr       = (state_q == WRITE);

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    localparam int LAT = 1;

    logic Clk;
    logic Reset_n;
    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_RD_LAT(LAT)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Byte-addressed memory model, 16-bit wrapping byte lanes, 2-state zero init.
    bit [7:0] mem [0:65535];

    always_comb begin
        bus.mem_dataout = '0;
        for (int i = 0; i < 8; i++)
            bus.mem_dataout[8*i +: 8] = mem[16'(bus.mem_raddress[15:0] + 16'(i))];
    end

    always @(posedge Clk) begin
        if (bus.mem_wr)
            for (int j = 0; j < 8; j++)
                mem[16'(bus.mem_waddress[15:0] + 16'(j))] <= bus.mem_datain[8*j +: 8];
    end

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        logic        wr;
        logic [63:0] datain;
        logic [63:0] addr;
    } exp_t;

    exp_t sb [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request; push its expectation, then pop and compare when the
    // response pulse appears. exp_rd is the load result, exp_din the store data.
    task automatic req(input string tag, input logic wr, input logic [1:0] sz,
                       input logic u, input logic [63:0] a, input logic [63:0] wd,
                       input logic [63:0] exp_rd, input logic [63:0] exp_din);
        exp_t e;
        logic mis;
        int   k;
        bit   seen;
        mis = 1'b0;
`ifdef ALIGN_CHECK_EN
        mis = (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
              (sz == 2'd3 && a[2:0] != 3'd0);
`endif
        e.err    = mis;
        e.rdata  = (mis || wr) ? 64'd0 : exp_rd;
        e.wr     = wr && !mis;
        e.datain = exp_din;
        e.addr   = a;
        e.lat    = mis ? 1 : (wr && sz == 2'd3) ? 1 : 1 + LAT;
        sb.push_back(e);

        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge Clk);
            k++;
        end
        chk({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        @(posedge Clk);
        #1 bus.req_valid = 1'b0;

        seen = 0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge Clk);
            if (c == 1) chk({tag, ".busy"}, 64'(bus.req_ready), 64'd0);
            if (bus.rsp_valid) begin
                seen = 1;
                e = sb.pop_front();
                chk({tag, ".lat"},   64'(c),           64'(e.lat));
                chk({tag, ".rdata"}, bus.rsp_rdata,    e.rdata);
                chk({tag, ".err"},   64'(bus.rsp_err), 64'(e.err));
                chk({tag, ".wr"},    64'(bus.mem_wr),  64'(e.wr));
                if (e.wr) begin
                    chk({tag, ".waddr"}, bus.mem_waddress, e.addr);
                    chk({tag, ".din"},   bus.mem_datain,   e.datain);
                end
                if (!e.err) chk({tag, ".raddr"}, bus.mem_raddress, e.addr);
            end else begin
                chk({tag, ".early_wr"}, 64'(bus.mem_wr), 64'd0);
            end
        end
        if (!seen) begin
            checks++;
            failures++;
            void'(sb.pop_front());
            $display("FAIL %s.timeout observed=no_rsp expected=rsp", tag);
        end
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        Reset_n          = 1'b0;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst.ready", 64'(bus.req_ready), 64'd1);
        chk("rst.rspv",  64'(bus.rsp_valid), 64'd0);
        chk("rst.wr",    64'(bus.mem_wr),    64'd0);
        chk("rst.rdata", bus.rsp_rdata,      64'd0);
        chk("rst.raddr", bus.mem_raddress,   64'd0);
        chk("rst.waddr", bus.mem_waddress,   64'd0);
        chk("rst.din",   bus.mem_datain,     64'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("rst.idle", 64'(bus.req_ready), 64'd1);

        // D store / D load
        req("st_d", 1, 2'd3, 0, 64'h10, 64'h0123456789ABCDEF, 64'd0, 64'h0123456789ABCDEF);
        req("ld_d", 0, 2'd3, 0, 64'h10, 64'd0, 64'h0123456789ABCDEF, 64'd0);

        // Extension variants on the same memory image
        req("ld_bs", 0, 2'd0, 0, 64'h11, 64'd0, 64'hFFFFFFFFFFFFFFCD, 64'd0);
        req("ld_bu", 0, 2'd0, 1, 64'h11, 64'd0, 64'h00000000000000CD, 64'd0);
        req("ld_hs", 0, 2'd1, 0, 64'h10, 64'd0, 64'hFFFFFFFFFFFFCDEF, 64'd0);
        req("ld_wu", 0, 2'd2, 1, 64'h10, 64'd0, 64'h0000000089ABCDEF, 64'd0);

        // B store read-modify-write, then back-to-back load of the result
        req("st_b",  1, 2'd0, 0, 64'h12, 64'h00000000000000AA, 64'd0, 64'h00000123456789AA);
        req("ld_d2", 0, 2'd3, 0, 64'h10, 64'd0, 64'h0123456789AACDEF, 64'd0);

        // Address passes through untouched; memory sees only the low 16 bits
        req("st_wrap", 1, 2'd3, 0, 64'hABCD00000000FFF8, 64'h1122334455667788, 64'd0, 64'h1122334455667788);
        req("ld_wrap", 0, 2'd3, 0, 64'h000000000000FFF8, 64'd0, 64'h1122334455667788, 64'd0);

        // Reset during RD_WAIT of an H store: nothing is written or answered
        while (!bus.req_ready) @(negedge Clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'd1;
        bus.req_addr  = 64'h20;
        bus.req_wdata = 64'hBEEF;
        @(posedge Clk);
        #1 bus.req_valid = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        chk("midrst.rspv",  64'(bus.rsp_valid), 64'd0);
        chk("midrst.wr",    64'(bus.mem_wr),    64'd0);
        chk("midrst.ready", 64'(bus.req_ready), 64'd1);
        #1 Reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge Clk);
            chk("midrst.no_rsp", 64'(bus.rsp_valid), 64'd0);
            chk("midrst.no_wr",  64'(bus.mem_wr),    64'd0);
        end
        chk("midrst.idle", 64'(bus.req_ready), 64'd1);
        req("ld_after_rst", 0, 2'd3, 0, 64'h20, 64'd0, 64'd0, 64'd0);

        // Unaligned accesses (rejected only with the alignment check)
        req("ld_w13", 0, 2'd2, 0, 64'h13, 64'd0, 64'h0000000023456789, 64'd0);
        req("ld_h11", 0, 2'd1, 0, 64'h11, 64'd0, 64'hFFFFFFFFFFFFAACD, 64'd0);

        repeat (2) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
